// File: rtl/lin_to_log_encoder.sv
// Sequential signed-linear to sign/log2 fixed-point encoder (leading-one + iterative squaring).
// Defaults for WBITS/FRACBITS come from size.v macros when defined; LOG_ROUND_EN enables rounding.
`ifndef WBITS
`define WBITS 8
`endif
`ifndef FRACBITS
`define FRACBITS 4
`endif

module lin_to_log_encoder #(
    parameter int unsigned WBITS    = `WBITS,
    parameter int unsigned FRACBITS = `FRACBITS,
    parameter int unsigned LINBITS  = 16,
    parameter int unsigned GBITS    = FRACBITS + 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LINBITS-1:0] lin_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WBITS-1:0]   log_out,
    output logic               sign_out,
    output logic               zero_out
);

    localparam int unsigned IBITS = WBITS - FRACBITS;
    localparam int unsigned MBITS = GBITS + 1;
    localparam int unsigned QBITS = 2 * MBITS;
`ifdef LOG_ROUND_EN
    localparam int unsigned NITER = FRACBITS + 1;
`else
    localparam int unsigned NITER = FRACBITS;
`endif
    localparam int unsigned KBITS = $clog2(NITER + 1);

    // The integer field must hold the leading-one index of any magnitude.
    if (IBITS < $clog2(LINBITS)) begin : g_width_check
        $fatal(1, "lin_to_log_encoder: integer field too narrow for LINBITS");
    end

    typedef enum logic [1:0] {StIdle, StNorm, StIter, StDone} state_e;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [LINBITS-1:0] mag_q, mag_d;
    logic [MBITS-1:0]   m_q, m_d;
    logic [WBITS-1:0]   acc_q, acc_d;
    logic [KBITS-1:0]   k_q, k_d;
    logic [WBITS-1:0]   log_q, log_d;
    logic               sign_out_q, sign_out_d;
    logic               zero_q, zero_d;

    int unsigned                lead;
    logic [LINBITS-1:0]         norm;
    logic [LINBITS+GBITS-1:0]   norm_ext;
    logic [MBITS-1:0]           m_norm;
    logic [QBITS-1:0]           sq;
    logic                       sq_bit;
    logic [MBITS-1:0]           m_sq;
    logic [WBITS-1:0]           acc_shift;

    always_comb begin
        lead = 0;
        for (int i = 0; i < LINBITS; i++) begin
            if (mag_q[i]) lead = i;
        end
        norm     = mag_q << (LINBITS - 1 - lead);
        norm_ext = {norm, {GBITS{1'b0}}};
        m_norm   = norm_ext[LINBITS+GBITS-1 -: MBITS];

        // m in [1,2) so m*m in [1,4): the top bit says whether the square reached 2.
        sq        = QBITS'(m_q) * QBITS'(m_q);
        sq_bit    = sq[QBITS-1];
        m_sq      = sq_bit ? sq[QBITS-1 -: MBITS] : sq[QBITS-2 -: MBITS];
        acc_shift = {acc_q[WBITS-1:FRACBITS], FRACBITS'({acc_q[FRACBITS-1:0], sq_bit})};
    end

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        m_d        = m_q;
        acc_d      = acc_q;
        k_d        = k_q;
        log_d      = log_q;
        sign_out_d = sign_out_q;
        zero_d     = zero_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d  = lin_in[LINBITS-1];
                    mag_d   = lin_in[LINBITS-1] ? -lin_in : lin_in;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (mag_q == '0) begin
                    log_d      = {1'b1, {(WBITS-1){1'b0}}};
                    zero_d     = 1'b1;
                    sign_out_d = 1'b0;
                    state_d    = StDone;
                end else begin
                    m_d     = m_norm;
                    acc_d   = {IBITS'(lead), {FRACBITS{1'b0}}};
                    k_d     = '0;
                    state_d = StIter;
                end
            end
            StIter: begin
                m_d = m_sq;
                k_d = k_q + 1'b1;
`ifdef LOG_ROUND_EN
                if (k_q == KBITS'(FRACBITS)) begin
                    // Guard bit: round {p, fraction} up, carry may reach the integer field.
                    log_d      = acc_q + WBITS'(sq_bit);
                    sign_out_d = sign_q;
                    zero_d     = 1'b0;
                    state_d    = StDone;
                end else begin
                    acc_d = acc_shift;
                end
`else
                acc_d = acc_shift;
                if (k_q == KBITS'(FRACBITS - 1)) begin
                    log_d      = acc_shift;
                    sign_out_d = sign_q;
                    zero_d     = 1'b0;
                    state_d    = StDone;
                end
`endif
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            log_q      <= '0;
            sign_out_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            m_q        <= m_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            log_q      <= log_d;
            sign_out_q <= sign_out_d;
            zero_q     <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign log_out   = log_q;
    assign sign_out  = sign_out_q;
    assign zero_out  = zero_q;

endmodule

// File: tb/tb_lin_to_log_encoder.sv
// Scoreboard bench for lin_to_log_encoder (FRACBITS=4, WBITS=8, LINBITS=16).
module tb_lin_to_log_encoder;

    localparam int WB = 8;
    localparam int FB = 4;
    localparam int LB = 16;
    localparam int GB = FB + 4;
`ifdef LOG_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int LAT = FB + 1 + RND;

    typedef struct {
        logic [WB-1:0] log;
        logic          sign;
        logic          zero;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LB-1:0] lin_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WB-1:0] log_out;
    logic          sign_out;
    logic          zero_out;

    int            n_checks = 0;
    int            n_errs = 0;
    exp_t          sb_q[$];
    logic [WB-1:0] last_log;
    logic          last_sign;

    lin_to_log_encoder #(
        .WBITS(WB),
        .FRACBITS(FB),
        .LINBITS(LB),
        .GBITS(GB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .lin_in(lin_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .log_out(log_out),
        .sign_out(sign_out),
        .zero_out(zero_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer scaled by 2^GB, squaring loop written from the algorithm description.
    function automatic exp_t model(input logic signed [LB-1:0] v);
        exp_t        e;
        int unsigned mag, p, m, q, fr, b, val;
        mag = (v < 0) ? unsigned'(-int'(v)) : unsigned'(int'(v));
        if (mag == 0) begin
            e.log = 8'h80; e.sign = 1'b0; e.zero = 1'b1; e.lat = 1;
            return e;
        end
        p = 0;
        for (int i = 0; i < LB; i++) if (((mag >> i) & 1) == 1) p = i;
        m  = (mag << GB) >> p;
        fr = 0;
        for (int n = 0; n < FB + RND; n++) begin
            q  = m * m;
            b  = (q >= (32'd2 << (2 * GB))) ? 1 : 0;
            m  = (b == 1) ? (q >> (GB + 1)) : (q >> GB);
            fr = (fr << 1) | b;
        end
        if (RND == 1) val = (p << FB) + (fr >> 1) + (fr & 1);
        else          val = (p << FB) | fr;
        e.log  = val[WB-1:0];
        e.sign = (v < 0);
        e.zero = 1'b0;
        e.lat  = LAT;
        return e;
    endfunction

    task automatic convert(input logic [LB-1:0] v, input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        check_eq("in_ready_idle", in_ready, 1);
        lin_in   = v;
        in_valid = 1'b1;
        @(posedge clk);
        sb_q.push_back(model(v));
        @(negedge clk);
        in_valid = 1'b0;
        lin_in   = 16'h1234;
        check_eq("in_ready_busy", in_ready, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check_eq("out_valid_seen", out_valid, 1);
        e = sb_q.pop_front();
        check_eq("latency", n, e.lat);
        check_eq("log_out", log_out, e.log);
        check_eq("sign_out", sign_out, e.sign);
        check_eq("zero_out", zero_out, e.zero);
        last_log  = log_out;
        last_sign = sign_out;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            lin_in   = 16'd3;
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_log", log_out, e.log);
            check_eq("hold_sign", sign_out, e.sign);
            check_eq("hold_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_hs_valid", out_valid, 0);
        check_eq("post_hs_ready", in_ready, 1);
    endtask

    initial begin
        int n;
        int ghost;
        logic [LB-1:0] rv;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_log", log_out, 0);
        check_eq("rst_sign", sign_out, 0);
        check_eq("rst_zero", zero_out, 0);
        rst = 1'b0;

        convert(16'd1, 0);
        check_eq("lin1_plan", last_log, 8'h00);
        convert(16'd8, 0);
        check_eq("lin8_plan", last_log, 8'h30);
        convert(-16'sd8, 0);
        check_eq("linm8_plan", last_log, 8'h30);
        check_eq("linm8_sign", last_sign, 1);
        convert(16'd0, 0);
        check_eq("lin0_plan", last_log, 8'h80);
        convert(16'd7, 1);
        check_eq("lin7_plan", last_log, (RND == 1) ? 8'h2D : 8'h2C);
        convert(16'h8000, 10);
        check_eq("min_plan", last_log, 8'hF0);
        check_eq("min_sign", last_sign, 1);
        convert(16'h7FFF, 0);

        // Reset during the second ITER cycle discards the conversion.
        @(negedge clk);
        lin_in = 16'd100; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        ghost = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) ghost++;
        end
        check_eq("midrst_no_result", ghost, 0);
        convert(16'd5, 0);
        check_eq("lin5_plan", last_log, 8'h25);

        // Reset while a result is presented.
        @(negedge clk);
        lin_in = -16'sd8; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_reached", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("donerst_valid", out_valid, 0);
        check_eq("donerst_log", log_out, 0);
        check_eq("donerst_sign", sign_out, 0);
        check_eq("donerst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rv = LB'($urandom);
            convert(rv, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
